crc16_frame_tx: RTL

Byte-stream framer that sits directly upstream of the serial/PHY transmit path and drives the CRC16-CCITT engine. It accepts payload bytes on a valid/ready stream and forwards them through a one-entry output register. On the last payload byte it appends the 16-bit CRC of the frame, high byte first, and marks the final CRC byte with `m_last`. The CRC is polynomial 1+x^5+x^12+x^16, MSB-first, with no output XOR.

---
 rtl/crc16_tx_pkg.sv | 26 ++
 rtl/crc16_CCITT.sv | 31 +++
 rtl/crc16_frame_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/crc16_tx_pkg.sv
// Shared types and helpers for the CRC16-CCITT frame transmitter.
// Holds the FSM state type, the frame-count width and the byte-wise CRC step.
package crc16_tx_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      CRC_HI = 2'd2,
      CRC_LO = 2'd3
   } tx_state_e;

   localparam int FRAME_CNT_W = 16;
   localparam logic [15:0] CRC_POLY = 16'h1021;

   // One byte through the x^16+x^12+x^5+1 divider, MSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_CCITT.sv
// Byte-wide CRC16-CCITT engine: absorbs data_in when crc_en, reseeds on sync_reset.
module crc16_CCITT
   import crc16_tx_pkg::*;
#(
   parameter logic [15:0] INIT_VALUE = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sync_reset,
   input  logic        crc_en,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (sync_reset)  crc_d = INIT_VALUE;
      else if (crc_en) crc_d = crc16_byte(crc_q, data_in);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) crc_q <= INIT_VALUE;
      else          crc_q <= crc_d;
   end

   assign crc_out = crc_q;

endmodule

// File: rtl/crc16_frame_tx.sv
// Framer: forwards payload bytes through a one-entry output register and appends the CRC16.
// Optional CRC16_TX_ERR_INJECT_EN adds inject_err, flipping bit 0 of the sent CRC low byte.
module crc16_frame_tx
   import crc16_tx_pkg::*;
#(
   parameter logic [15:0] INIT_VALUE = 16'hFFFF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   sync_reset,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [7:0]             s_data,
   input  logic                   s_last,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [7:0]             m_data,
   output logic                   m_last,
   output logic                   frame_done,
`ifdef CRC16_TX_ERR_INJECT_EN
   input  logic                   inject_err,
`endif
   output logic [FRAME_CNT_W-1:0] frame_count
);

   tx_state_e              state_q, state_d;
   logic                   m_valid_q, m_valid_d;
   logic [7:0]             m_data_q, m_data_d;
   logic                   m_last_q, m_last_d;
   logic                   inj_q, inj_d;
   logic [FRAME_CNT_W-1:0] frame_count_q;
   logic                   free;
   logic                   crc_en;
   logic                   crc_clr;
   logic                   done;
   logic [15:0]            crc_out;

   assign free    = !m_valid_q || m_ready;
   assign s_ready = ((state_q == IDLE) || (state_q == DATA)) && free;
   assign done    = m_valid_q && m_ready && m_last_q && !sync_reset;

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      inj_d     = inj_q;
      crc_en    = 1'b0;
      crc_clr   = 1'b0;

      // An accepted beat empties the register unless something reloads it below.
      if (free) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end

      unique case (state_q)
         IDLE, DATA: begin
            if (s_valid && free) begin
               m_data_d  = s_data;
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               crc_en    = 1'b1;
               state_d   = s_last ? CRC_HI : DATA;
`ifdef CRC16_TX_ERR_INJECT_EN
               if (s_last) inj_d = inject_err;
`endif
            end
         end
         CRC_HI: begin
            if (free) begin
               m_data_d  = crc_out[15:8];
               m_valid_d = 1'b1;
               m_last_d  = 1'b0;
               state_d   = CRC_LO;
            end
         end
         CRC_LO: begin
            if (free) begin
               m_data_d  = crc_out[7:0] ^ {7'b0, inj_q};
               m_valid_d = 1'b1;
               m_last_d  = 1'b1;
               crc_clr   = 1'b1;
               inj_d     = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (sync_reset) begin
         state_d   = IDLE;
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
         inj_d     = 1'b0;
         crc_en    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
         m_last_q  <= 1'b0;
         inj_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         inj_q     <= inj_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  frame_count_q <= '0;
      else if (done) frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
   end

   crc16_CCITT #(
      .INIT_VALUE (INIT_VALUE)
   ) u_crc (
      .clk        (clk),
      .reset_n    (reset_n),
      .sync_reset (sync_reset || crc_clr),
      .crc_en     (crc_en),
      .data_in    (s_data),
      .crc_out    (crc_out)
   );

   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_last      = m_last_q;
   assign frame_done  = done;
   assign frame_count = frame_count_q;

endmodule
